// File: rtl/shreg_job_if.sv
// Job channel into the shift-register sequencer: one parallel byte plus shift
// parameters, transferred on valid & ready.
interface shreg_job_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             dir;
  logic [3:0]       count;
  logic             fill;
  logic             valid;
  logic             ready;

  modport master (output data, dir, count, fill, valid, input ready);
  modport slave  (input data, dir, count, fill, valid, output ready);
endinterface

// File: rtl/shreg_sequencer.sv
// Drives an 8-bit universal shift register through load / N shifts / hold for
// each accepted job, and streams out every bit leaving the register.
module shreg_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shreg_job_if.slave       job,
  input  logic             q0,
  input  logic             q7,
  output logic             A1,
  output logic             A0,
  output logic [WIDTH-1:0] D,
  output logic             DL,
  output logic             DR,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] MAX_SHIFTS = 4'(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_r, data_nxt;
  logic             dir_r, dir_nxt;
  logic             fill_r, fill_nxt;
  logic [3:0]       cnt_r, cnt_nxt;
  logic             ready_q;

  logic [1:0]       mode_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             dl_nxt, dr_nxt, sv_nxt, busy_nxt, done_nxt, ready_nxt;

  assign job.ready = ready_q;

  // Outgoing bit is whichever end the register is about to shift out of.
  assign ser_bit = ser_valid & (dir_r ? q7 : q0);

  // Next-state logic, then Moore outputs decoded from the next state so they
  // can be registered without adding latency.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_r;
    dir_nxt   = dir_r;
    fill_nxt  = fill_r;
    cnt_nxt   = cnt_r;

    case (state)
      IDLE: begin
        if (job.valid) begin
          data_nxt  = job.data;
          dir_nxt   = job.dir;
          fill_nxt  = job.fill;
          cnt_nxt   = (job.count > MAX_SHIFTS) ? MAX_SHIFTS : job.count;
          state_nxt = LOAD;
        end
      end
      LOAD:    state_nxt = (cnt_r != 4'd0) ? SHIFT : DONE;
      SHIFT: begin
        cnt_nxt = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    mode_nxt  = 2'b00;
    d_nxt     = '0;
    dl_nxt    = 1'b0;
    dr_nxt    = 1'b0;
    sv_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    ready_nxt = 1'b0;

    case (state_nxt)
      IDLE:  ready_nxt = 1'b1;
      LOAD: begin
        mode_nxt = 2'b11;
        d_nxt    = data_nxt;
        busy_nxt = 1'b1;
      end
      SHIFT: begin
        mode_nxt = dir_nxt ? 2'b10 : 2'b01;
        dl_nxt   = dir_nxt & fill_nxt;
        dr_nxt   = ~dir_nxt & fill_nxt;
        sv_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ready_nxt = 1'b0;
    endcase
  end

  // State, job registers and output flops; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_r    <= '0;
      dir_r     <= 1'b0;
      fill_r    <= 1'b0;
      cnt_r     <= 4'd0;
      A1        <= 1'b0;
      A0        <= 1'b0;
      D         <= '0;
      DL        <= 1'b0;
      DR        <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      data_r    <= data_nxt;
      dir_r     <= dir_nxt;
      fill_r    <= fill_nxt;
      cnt_r     <= cnt_nxt;
      A1        <= mode_nxt[1];
      A0        <= mode_nxt[0];
      D         <= d_nxt;
      DL        <= dl_nxt;
      DR        <= dr_nxt;
      ser_valid <= sv_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ready_q   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_shreg_sequencer.sv
// Directed bench for shreg_sequencer with a behavioural 8-bit universal shift
// register hanging off its mode/data/fill outputs.
module tb_shreg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       A1, A0, DL, DR, ser_bit, ser_valid, busy, done;
  logic [7:0] D;
  logic [7:0] sr = 8'h00;
  int         n_pass  = 0;
  int         n_total = 0;

  shreg_job_if #(.WIDTH(8)) job ();

  shreg_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job       (job),
    .q0        (sr[0]),
    .q7        (sr[7]),
    .A1        (A1),
    .A0        (A0),
    .D         (D),
    .DL        (DL),
    .DR        (DR),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Universal shift register; not reset, so it keeps contents across rst_n.
  always @(posedge clk) begin
    case ({A1, A0})
      2'b01:   sr <= {DR, sr[7:1]};
      2'b10:   sr <= {sr[6:0], DL};
      2'b11:   sr <= D;
      default: sr <= sr;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one job for exactly one edge; returns in the LOAD cycle.
  task automatic send(input logic [7:0] d, input logic dir, input logic [3:0] c, input logic f);
    job.data  = d;
    job.dir   = dir;
    job.count = c;
    job.fill  = f;
    job.valid = 1'b1;
    tick();
    job.valid = 1'b0;
  endtask

  // Walks n shift cycles checking the outgoing bit stream (bits[i] = i-th bit out).
  task automatic shift_phase(input string tag, input logic [7:0] bits, input int n,
                             input logic [1:0] mode, input logic dl_e, input logic dr_e);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_sv"}, 32'(ser_valid), 32'd1);
      chk({tag, "_bit"}, 32'(ser_bit), 32'(bits[i]));
      chk({tag, "_mode"}, 32'({A1, A0}), 32'(mode));
      if (i == 0) begin
        chk({tag, "_dl"}, 32'(DL), 32'(dl_e));
        chk({tag, "_dr"}, 32'(DR), 32'(dr_e));
      end
      tick();
    end
  endtask

  // Runs until done, counting shift cycles; a missing done counts as a failure.
  task automatic run_to_done(input string tag, output int nsh);
    logic got;
    got = 1'b0;
    nsh = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ser_valid) nsh++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int nsh;
    rst_n     = 1'b0;
    job.valid = 1'b0;
    job.data  = 8'h00;
    job.dir   = 1'b0;
    job.count = 4'd0;
    job.fill  = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_mode", 32'({A1, A0}), 32'd0);
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_fill", 32'({DL, DR}), 32'd0);
    chk("rst_ready", 32'(job.ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sv", 32'(ser_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // load only, count 0
    send(8'hA5, 1'b0, 4'd0, 1'b0);
    chk("lo_mode", 32'({A1, A0}), 32'd3);
    chk("lo_d", 32'(D), 32'hA5);
    chk("lo_ready", 32'(job.ready), 32'd0);
    chk("lo_busy", 32'(busy), 32'd1);
    tick();
    chk("lo_done", 32'(done), 32'd1);
    chk("lo_mode2", 32'({A1, A0}), 32'd0);
    chk("lo_sv", 32'(ser_valid), 32'd0);
    chk("lo_reg", 32'(sr), 32'hA5);
    chk("lo_busy2", 32'(busy), 32'd0);
    tick();
    chk("lo_ready2", 32'(job.ready), 32'd1);
    chk("lo_done2", 32'(done), 32'd0);

    // shift toward Q0, 8 shifts, fill 0: A5 leaves LSB first
    send(8'hA5, 1'b0, 4'd8, 1'b0);
    chk("q0_load", 32'({A1, A0}), 32'd3);
    tick();
    shift_phase("q0", 8'hA5, 8, 2'b01, 1'b0, 1'b0);
    chk("q0_done", 32'(done), 32'd1);
    chk("q0_reg", 32'(sr), 32'h00);
    chk("q0_sv_end", 32'(ser_valid), 32'd0);
    tick();
    chk("q0_ready", 32'(job.ready), 32'd1);

    // shift toward Q7, 3 shifts, fill 1: 81 -> bits 1,0,0, register 0F
    send(8'h81, 1'b1, 4'd3, 1'b1);
    tick();
    shift_phase("q7", 8'h01, 3, 2'b10, 1'b1, 1'b0);
    chk("q7_done", 32'(done), 32'd1);
    chk("q7_reg", 32'(sr), 32'h0F);
    tick();

    // hold for 20 idle cycles
    for (int i = 0; i < 20; i++) begin
      chk("hold_mode", 32'({A1, A0}), 32'd0);
      tick();
    end
    chk("hold_reg", 32'(sr), 32'h0F);
    chk("hold_ready", 32'(job.ready), 32'd1);

    // clamp 15 -> 8 with in_valid held high; data changed right after accept
    job.data  = 8'h3C;
    job.dir   = 1'b1;
    job.count = 4'd15;
    job.fill  = 1'b0;
    job.valid = 1'b1;
    tick();
    job.data = 8'h66;
    chk("bb_load_d", 32'(D), 32'h3C);
    chk("bb_load_mode", 32'({A1, A0}), 32'd3);
    run_to_done("bb1", nsh);
    chk("bb1_shifts", 32'(nsh), 32'd8);
    chk("bb1_reg", 32'(sr), 32'h00);
    chk("bb1_ready_done", 32'(job.ready), 32'd0);
    tick();
    chk("bb_ready_back", 32'(job.ready), 32'd1);
    chk("bb_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("bb2_mode", 32'({A1, A0}), 32'd3);
    chk("bb2_d", 32'(D), 32'h66);
    job.valid = 1'b0;
    run_to_done("bb2", nsh);
    chk("bb2_shifts", 32'(nsh), 32'd8);
    tick();
    chk("bb2_ready", 32'(job.ready), 32'd1);

    // reset in the middle of a shift job
    send(8'hA5, 1'b0, 4'd8, 1'b0);
    tick();
    tick();
    chk("mr_pre_reg", 32'(sr), 32'h52);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_mode", 32'({A1, A0}), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(job.ready), 32'd1);
    chk("mr_sv", 32'(ser_valid), 32'd0);
    chk("mr_d", 32'(D), 32'd0);
    repeat (2) tick();
    chk("mr_reg_held", 32'(sr), 32'h52);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_reg_after", 32'(sr), 32'h52);
    chk("mr_ready_after", 32'(job.ready), 32'd1);
    chk("mr_mode_after", 32'({A1, A0}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
